// File: rtl/sound_level_meter.sv
// Sound level meter: counts comparator ones over a window of sample strobes and
// turns the count into a 0..8 level, a held/decaying peak and an LED bar graph.
module sound_level_meter #(
   parameter int WINDOW   = 64,
   parameter int HOLD_WIN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_en,
   input  logic       aout_raw,
   input  logic       dout_raw,
   output logic [3:0] level,
   output logic       level_valid,
   output logic [3:0] peak,
   output logic [7:0] led,
   output logic       clip,
   output logic       dout_sync
);

   localparam int CW = $clog2(WINDOW) + 1;

   typedef enum logic {ACCUM, UPDATE} state_t;

   state_t         state, state_next;
   logic           a_meta, aout_s, d_meta;
   logic [CW-1:0]  win_cnt, ones_cnt, total;
   logic [3:0]     hold_cnt;
   logic           window_full, count_en, do_update, wrap;
   logic [3:0]     new_level, new_peak, new_hold;
   logic [7:0]     led_next;

   // Two-flop synchronizers for the sensor outputs, which are asynchronous to clk.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_meta    <= 1'b0;
         aout_s    <= 1'b0;
         d_meta    <= 1'b0;
         dout_sync <= 1'b0;
      end else begin
         a_meta    <= aout_raw;
         aout_s    <= a_meta;
         d_meta    <= dout_raw;
         dout_sync <= d_meta;
      end
   end

   assign window_full = (win_cnt == CW'(WINDOW));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACCUM;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ACCUM:   if (window_full) state_next = UPDATE;
         UPDATE:  state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   // A strobe in the UPDATE cycle is sample 1 of the next window; the wrap cycle takes none.
   always_comb begin
      wrap      = (state == ACCUM) && window_full;
      do_update = (state == UPDATE);
      count_en  = sample_en && !wrap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt  <= '0;
         ones_cnt <= '0;
         total    <= '0;
      end else if (wrap) begin
         total    <= ones_cnt;
         win_cnt  <= '0;
         ones_cnt <= '0;
      end else if (count_en) begin
         win_cnt  <= win_cnt + CW'(1);
         ones_cnt <= ones_cnt + CW'(aout_s);
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      new_level = 4'((32'(total) * 8) / WINDOW);
      new_peak  = peak;
      new_hold  = hold_cnt;
      if (new_level >= peak) begin
         new_peak = new_level;
         new_hold = 4'(HOLD_WIN);
      end else if (hold_cnt != 4'd0) begin
         new_hold = hold_cnt - 4'd1;
      end else if (peak != 4'd0) begin
         new_peak = peak - 4'd1;
      end
      led_next = '0;
      for (int i = 0; i < 8; i++) led_next[i] = (4'(i) < new_level);
      if (new_peak != 4'd0) led_next[3'(new_peak - 4'd1)] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level       <= '0;
         peak        <= '0;
         hold_cnt    <= '0;
         led         <= '0;
         clip        <= 1'b0;
         level_valid <= 1'b0;
      end else begin
         level_valid <= do_update;
         if (do_update) begin
            level    <= new_level;
            peak     <= new_peak;
            hold_cnt <= new_hold;
            led      <= led_next;
            clip     <= (total == CW'(WINDOW));
         end
      end
   end

endmodule
